// File: rtl/insn_commit_tracker.sv
// Debug shadow pipeline for the 5-stage core: carries PC/ctrl/mispredict to WB and emits one retire pulse per instruction.
// Optional retire and mispredict counters are enabled by defining COMMIT_TRACKER_CNT_EN.
module insn_commit_tracker #(
  parameter int unsigned PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [PC_W-1:0] i_if_pc,
  input  logic            i_if_vld,
  input  logic            i_id_ctrl,
  input  logic            i_ex_mispred,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic            o_insn_vld,
  output logic [PC_W-1:0] o_pc_debug,
  output logic            o_ctrl,
  output logic            o_mispred
`ifdef COMMIT_TRACKER_CNT_EN
  ,
  output logic [31:0]     o_retire_cnt,
  output logic [31:0]     o_mispred_cnt
`endif
);

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic            ctrl;
  } idex_t;

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic            ctrl;
    logic            mis;
  } exmem_t;

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic            ctrl;
    logic            mis;
    logic            rep;
  } memwb_t;

  ifid_t  ifid_q,  ifid_d;
  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  // Stage registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Next-state: hold > flush > stall > advance; rep marks an entry already reported while frozen
  always_comb begin
    ifid_d  = ifid_q;
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (i_hold) begin
      memwb_d.rep = memwb_q.rep | memwb_q.vld;
    end else begin
      exmem_d.vld  = idex_q.vld;
      exmem_d.pc   = idex_q.pc;
      exmem_d.ctrl = idex_q.ctrl;
      exmem_d.mis  = i_ex_mispred & idex_q.vld & idex_q.ctrl;
      memwb_d.vld  = exmem_q.vld;
      memwb_d.pc   = exmem_q.pc;
      memwb_d.ctrl = exmem_q.ctrl;
      memwb_d.mis  = exmem_q.mis;
      memwb_d.rep  = 1'b0;
      if (i_flush) begin
        ifid_d.vld  = 1'b0;
        ifid_d.pc   = i_if_pc;
        idex_d.vld  = 1'b0;
        idex_d.pc   = ifid_q.pc;
        idex_d.ctrl = 1'b0;
      end else if (i_stall) begin
        idex_d.vld  = 1'b0;
        idex_d.pc   = ifid_q.pc;
        idex_d.ctrl = 1'b0;
      end else begin
        ifid_d.vld  = i_if_vld;
        ifid_d.pc   = i_if_pc;
        idex_d.vld  = ifid_q.vld;
        idex_d.pc   = ifid_q.pc;
        idex_d.ctrl = i_id_ctrl & ifid_q.vld;
      end
    end
  end

  // Outputs depend only on MEM/WB state
  always_comb begin
    o_insn_vld = memwb_q.vld & ~memwb_q.rep;
    o_pc_debug = memwb_q.pc;
    o_ctrl     = o_insn_vld & memwb_q.ctrl;
    o_mispred  = o_insn_vld & memwb_q.mis;
  end

`ifdef COMMIT_TRACKER_CNT_EN
  localparam int unsigned CNT_W = 32;

  // Free-running event counters, wrap naturally
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_retire_cnt  <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (o_insn_vld) o_retire_cnt  <= o_retire_cnt + CNT_W'(1);
      if (o_mispred)  o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/insn_commit_tracker.md
Name: insn_commit_tracker

Overview:
- Debug shadow pipeline alongside the 5-stage forwarding core (IF, ID, EX, MEM, WB).
- Carries PC, valid, control-transfer and mispredict flags per instruction through the stage registers, honouring stall, flush and global hold.
- Produces the WB-aligned debug outputs consumed by the testbench scoreboard: one pulse per retired instruction, never double-counted.

Parameters:
- PC_W, 32, width of the PC carried and reported.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_if_pc  in  PC_W  PC of the instruction in IF.
- i_if_vld  in  1  IF holds a real fetched instruction.
- i_id_ctrl  in  1  instruction in ID is branch/JAL/JALR (decoder output).
- i_ex_mispred  in  1  instruction in EX resolved as mispredicted.
- i_stall  in  1  load-use stall: hold IF/ID, insert bubble into ID/EX.
- i_flush  in  1  redirect: kill IF/ID and ID/EX contents.
- i_hold  in  1  global freeze (multi-cycle memory): all stage registers hold.
- o_insn_vld  out  1  an instruction retires this cycle.
- o_pc_debug  out  PC_W  PC of the retiring instruction.
- o_ctrl  out  1  retiring instruction is a control transfer.
- o_mispred  out  1  retiring control transfer was mispredicted.

Behaviour:
- Stage registers: IF/ID {vld, pc}; ID/EX {vld, pc, ctrl}; EX/MEM {vld, pc, ctrl, mis}; MEM/WB {vld, pc, ctrl, mis, rep}.
- Reset (async, i_reset=0): all vld, ctrl, mis and rep bits = 0; all pc fields = 0. Outputs during reset: o_insn_vld=0, o_pc_debug=0, o_ctrl=0, o_mispred=0.
- Latency: an instruction presented in IF in cycle N, with no stall, flush or hold, drives o_insn_vld=1 with its PC in cycle N+4.
- Capture points:
  - IF/ID <= {i_if_vld, i_if_pc}.
  - ID/EX.ctrl <= i_id_ctrl & IF/ID.vld.
  - EX/MEM.mis <= i_ex_mispred & ID/EX.vld & ID/EX.ctrl.
  - i_ex_mispred arriving with an invalid or non-control EX entry is ignored (mis=0).
- i_stall=1: IF/ID holds; ID/EX <= bubble (vld=0, ctrl=0); EX/MEM and MEM/WB advance normally.
- i_flush=1: IF/ID.vld <= 0, ID/EX.vld <= 0. The EX entry that caused the flush still advances to EX/MEM with its mis flag.
- Priority, highest first: i_reset > i_hold > i_flush > i_stall > normal advance.
  - i_flush together with i_stall: flush wins, both younger slots are cleared.
  - i_hold together with any other control: every register holds; flush and stall are lost for that cycle and the core must re-present them.
- Single-report rule:
  - MEM/WB.rep <= 1 when i_hold=1 and MEM/WB.vld=1.
  - MEM/WB.rep <= 0 whenever MEM/WB loads a new entry.
  - o_insn_vld = MEM/WB.vld & ~MEM/WB.rep.
  - o_ctrl = o_insn_vld & MEM/WB.ctrl; o_mispred = o_insn_vld & MEM/WB.mis.
  - o_pc_debug = MEM/WB.pc, unconditionally.
- Outputs are derived only from MEM/WB state, with no combinational path from any input. Sampling on the negative clock edge is safe.
- PC is carried unmodified; no arithmetic on it, so wrap-around is a non-issue.
- Reset asserted mid-operation: all in-flight entries are discarded immediately; no retire pulse follows reset release until a fresh instruction reaches WB.

Optional Feature:
- Macro: COMMIT_TRACKER_CNT_EN.
- When defined: adds outputs o_retire_cnt (32 bits) and o_mispred_cnt (32 bits).
  - o_retire_cnt increments on each cycle with o_insn_vld=1; o_mispred_cnt increments on each cycle with o_mispred=1.
  - Both counters clear on reset and wrap from 32'hFFFF_FFFF to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Straight line: i_if_vld=1 with PCs 0x0, 0x4, 0x8, 0xC in cycles 1-4 -> o_insn_vld=1 in cycles 5-8 with o_pc_debug 0x0, 0x4, 0x8, 0xC; o_ctrl=0 and o_mispred=0 throughout.
- Load-use stall: i_stall=1 for one cycle while PC 0x8 is in ID -> exactly one cycle with o_insn_vld=0 between retirement of 0x4 and 0x8; 0x8 retires once.
- Mispredict: branch at 0x10 with i_id_ctrl=1, then i_ex_mispred=1 and i_flush=1 in its EX cycle -> 0x10 retires with o_ctrl=1 and o_mispred=1; 0x14 and 0x18 never retire; redirect target 0x40 retires next.
- Hold at WB: i_hold=1 for 3 cycles while 0x20 is in MEM/WB -> o_insn_vld=1 for one cycle only; o_pc_debug stays 0x20 for all 4 cycles.
- Stale mispredict: i_ex_mispred=1 while EX holds a bubble, or a non-control instruction at 0x24 -> no o_mispred pulse; 0x24 retires with o_mispred=0.
- Reset mid-run: i_reset=0 asynchronously between clock edges with 4 entries in flight -> all outputs read 0 immediately; after release, no retire pulse until a new PC has had 4 cycles to reach WB. Under COMMIT_TRACKER_CNT_EN, both counters read 0.
